// File: rtl/vga_out_pkg.sv
// Shared types for the vga_out output-mode sequencer.
package vga_out_pkg;

    // Output-mode configuration as seen by vga_out
    typedef struct packed {
        logic ypbpr_en;
        logic ypbpr_full;
    } vmode_t;

    // Mode-change sequencer states
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        ARMED = 2'd1,
        MUTE  = 2'd2
    } vmc_state_t;

    localparam logic [23:0] BLACK_PIXEL = 24'h000000;

endpackage

// File: rtl/vga_sync_edge.sv
// Sync polarity normaliser with a leading-edge pulse.
// The pulse is high in the cycle the normalised sync first goes active.
module vga_sync_edge #(
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_in,
    output logic rise
);

    logic act;
    logic act_q;

    assign act  = sync_in ^ ~ACTIVE_HIGH;
    assign rise = act & ~act_q;

    // Remember last cycle's active level so a leading edge can be spotted
    always_ff @(posedge clk) begin
        if (reset) begin
            act_q <= 1'b0;
        end else begin
            act_q <= act;
        end
    end

endmodule

// File: rtl/vga_out_mode_ctrl.sv
// Output-mode change sequencer in front of vga_out.
// New RGB/YPbPr configs are taken over valid/ready, held until the next
// vsync leading edge (or a timeout when vsync is absent), applied there,
// and followed by MUTE_FRAMES frames of black video.
module vga_out_mode_ctrl
    import vga_out_pkg::*;
#(
    parameter int VS_ACTIVE_HIGH = 1,
    parameter int MUTE_FRAMES    = 2,
    parameter int TIMEOUT_CYC    = 2000000,
    parameter int CNT_W          = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_valid,
    input  logic        cfg_ypbpr_en,
    input  logic        cfg_ypbpr_full,
    output logic        cfg_ready,
    input  logic [23:0] din,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        csync,
    output logic [23:0] dout,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        csync_o,
    output logic        ypbpr_en_o,
    output logic        ypbpr_full_o,
    output logic        busy,
    output logic        applied
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       MUTE_N   = 4'(MUTE_FRAMES);

    vmc_state_t       state;
    vmode_t           cur_cfg;
    vmode_t           pend_cfg;
    vmode_t           req_cfg;
    logic [CNT_W-1:0] tmo_cnt;
    logic [3:0]       frm_cnt;
    logic             vs_edge;
    logic             tick;
    logic             accept;
    logic             last_frame;
    logic             mute;

    vga_sync_edge #(
        .ACTIVE_HIGH(VS_ACTIVE_HIGH != 0)
    ) u_vs_edge (
        .clk    (clk),
        .reset  (reset),
        .sync_in(vsync),
        .rise   (vs_edge)
    );

    assign req_cfg.ypbpr_en   = cfg_ypbpr_en;
    assign req_cfg.ypbpr_full = cfg_ypbpr_full;

    assign tick       = vs_edge | (tmo_cnt == TMO_LAST);
    assign accept     = cfg_valid & cfg_ready;
    assign last_frame = (frm_cnt + 4'd1) == MUTE_N;

    assign ypbpr_en_o   = cur_cfg.ypbpr_en;
    assign ypbpr_full_o = cur_cfg.ypbpr_full;

    // Blank from the apply tick until the tick that completes the last mute frame
    always_comb begin
        mute = 1'b0;
        case (state)
            ARMED:   mute = tick && (MUTE_N != 4'd0);
            MUTE:    mute = !(tick && last_frame);
            default: mute = 1'b0;
        endcase
    end

    // Frame-boundary timeout: only runs while a change is in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == RUN || tick) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Mode-change sequencer with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            cur_cfg   <= '0;
            pend_cfg  <= '0;
            frm_cnt   <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            applied   <= 1'b0;
        end else begin
            applied <= 1'b0;
            case (state)
                RUN: begin
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (accept && (req_cfg != cur_cfg)) begin
                        pend_cfg  <= req_cfg;
                        state     <= ARMED;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ARMED: begin
                    if (tick) begin
                        cur_cfg <= pend_cfg;
                        applied <= 1'b1;
                        frm_cnt <= '0;
                        if (MUTE_N == 4'd0) begin
                            state     <= RUN;
                            cfg_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state <= MUTE;
                        end
                    end
                end
                MUTE: begin
                    if (tick) begin
                        frm_cnt <= frm_cnt + 4'd1;
                        if (last_frame) begin
                            state     <= RUN;
                            cfg_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= RUN;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // One-cycle video register; syncs ride along and are never blanked
    always_ff @(posedge clk) begin
        if (reset) begin
            dout    <= '0;
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
            csync_o <= 1'b0;
        end else begin
            dout    <= mute ? BLACK_PIXEL : din;
            hsync_o <= hsync;
            vsync_o <= vsync;
            csync_o <= csync;
        end
    end

endmodule

// File: tb/tb_vga_out_mode_ctrl.sv
// Self-checking bench for vga_out_mode_ctrl: directed vector table,
// hand-written multi-cycle sequences, then random traffic against a
// frame-level reference model.
module tb_vga_out_mode_ctrl;

    localparam int TMO = 100;
    localparam int MF  = 2;

    typedef struct packed {
        logic [23:0] dout;
        logic        hs;
        logic        vs;
        logic        cs;
        logic        en;
        logic        full;
        logic        busy;
        logic        applied;
        logic        ready;
    } outs_t;

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic        en;
        logic        full;
        logic        vs;
        logic [23:0] din;
        logic [23:0] expDout;
        logic        expEn;
        logic        expFull;
        logic        expBusy;
        logic        expApplied;
        logic        expReady;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_valid_b = 1'b0;
    logic        cfg_ypbpr_en = 1'b0;
    logic        cfg_ypbpr_full = 1'b0;
    logic [23:0] din = '0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        vsync_b = 1'b0;
    logic        csync = 1'b0;

    logic        cfg_ready, hsync_o, vsync_o, csync_o, ypbpr_en_o, ypbpr_full_o, busy, applied;
    logic [23:0] dout;
    logic        cfg_ready_b, hsync_o_b, vsync_o_b, csync_o_b, ypbpr_en_o_b, ypbpr_full_o_b, busy_b, applied_b;
    logic [23:0] dout_b;

    int total = 0;
    int bad = 0;

    // reference model state
    bit    mPend;
    bit    mPendEn;
    bit    mPendFull;
    int    mMuteLeft;
    int    mSince;
    bit    mPrevAct;
    outs_t mOut;

    vga_out_mode_ctrl #(
        .VS_ACTIVE_HIGH(1), .MUTE_FRAMES(MF), .TIMEOUT_CYC(TMO), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ypbpr_en(cfg_ypbpr_en),
        .cfg_ypbpr_full(cfg_ypbpr_full), .cfg_ready(cfg_ready), .din(din), .hsync(hsync),
        .vsync(vsync), .csync(csync), .dout(dout), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .csync_o(csync_o), .ypbpr_en_o(ypbpr_en_o), .ypbpr_full_o(ypbpr_full_o),
        .busy(busy), .applied(applied)
    );

    vga_out_mode_ctrl #(
        .VS_ACTIVE_HIGH(0), .MUTE_FRAMES(0), .TIMEOUT_CYC(TMO), .CNT_W(8)
    ) dut_b (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid_b), .cfg_ypbpr_en(cfg_ypbpr_en),
        .cfg_ypbpr_full(cfg_ypbpr_full), .cfg_ready(cfg_ready_b), .din(din), .hsync(hsync),
        .vsync(vsync_b), .csync(csync), .dout(dout_b), .hsync_o(hsync_o_b), .vsync_o(vsync_o_b),
        .csync_o(csync_o_b), .ypbpr_en_o(ypbpr_en_o_b), .ypbpr_full_o(ypbpr_full_o_b),
        .busy(busy_b), .applied(applied_b)
    );

    always #5 clk = ~clk;

    function automatic outs_t sampleA();
        outs_t o;
        o.dout = dout; o.hs = hsync_o; o.vs = vsync_o; o.cs = csync_o;
        o.en = ypbpr_en_o; o.full = ypbpr_full_o; o.busy = busy;
        o.applied = applied; o.ready = cfg_ready;
        return o;
    endfunction

    function automatic outs_t mkOuts(logic [23:0] d, logic hs, logic vs, logic cs, logic en,
                                     logic full, logic bsy, logic app, logic rdy);
        outs_t o;
        o.dout = d; o.hs = hs; o.vs = vs; o.cs = cs; o.en = en; o.full = full;
        o.busy = bsy; o.applied = app; o.ready = rdy;
        return o;
    endfunction

    // advance one clock and settle just after the edge
    task automatic tickClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic valid, input logic en,
                                 input logic full, input logic vs, input logic [23:0] d);
        reset = rst; cfg_valid = valid; cfg_ypbpr_en = en; cfg_ypbpr_full = full;
        vsync = vs; din = d;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Frame-level behaviour: a pending change waits for a frame boundary, then a
    // number of black frames is owed; boundaries are vsync leading edges or TMO
    // cycles without one while something is in flight.
    task automatic modelStep();
        bit act, edgeSeen, tick, blackNow;
        if (reset) begin
            mPend = 0; mMuteLeft = 0; mSince = 0; mPrevAct = 0;
            mOut = '0;
        end else begin
            act = vsync;
            edgeSeen = act && !mPrevAct;
            mPrevAct = act;
            tick = edgeSeen || (mSince == TMO - 1);
            blackNow = 0;
            mOut.applied = 0;
            if (mPend) begin
                if (tick) begin
                    mOut.en = mPendEn; mOut.full = mPendFull; mOut.applied = 1;
                    mPend = 0; mMuteLeft = MF; blackNow = (MF > 0); mSince = 0;
                end else begin
                    mSince++;
                end
            end else if (mMuteLeft > 0) begin
                if (tick) begin
                    mMuteLeft--; mSince = 0;
                end else begin
                    mSince++;
                end
                blackNow = (mMuteLeft > 0);
            end else begin
                mSince = 0;
                if (cfg_valid && mOut.ready &&
                    ({cfg_ypbpr_en, cfg_ypbpr_full} != {mOut.en, mOut.full})) begin
                    mPend = 1; mPendEn = cfg_ypbpr_en; mPendFull = cfg_ypbpr_full;
                end
            end
            mOut.dout = blackNow ? 24'h0 : din;
            mOut.hs = hsync; mOut.vs = vsync; mOut.cs = csync;
            mOut.busy = mPend || (mMuteLeft > 0);
            mOut.ready = !mOut.busy;
        end
    endtask

    initial begin
        vec_t  vecs[21];
        outs_t e;
        int    n, m, blackBad;

        // rst valid en full vs din | dout en full busy applied ready
        for (int i = 0; i < 5; i++) vecs[i] = '{1,0,0,0,0,24'h111111, 24'h000000,0,0,0,0,0};
        vecs[5]  = '{0,0,0,0,0,24'hA1B2C3, 24'hA1B2C3,0,0,0,0,1};
        vecs[6]  = '{0,0,0,0,0,24'h123456, 24'h123456,0,0,0,0,1};
        vecs[7]  = '{0,1,1,0,0,24'h0F0F0F, 24'h0F0F0F,0,0,1,0,0};
        vecs[8]  = '{0,0,0,0,0,24'h222222, 24'h222222,0,0,1,0,0};
        vecs[9]  = '{0,0,0,0,1,24'h333333, 24'h000000,1,0,1,1,0};
        vecs[10] = '{0,0,0,0,1,24'h444444, 24'h000000,1,0,1,0,0};
        vecs[11] = '{0,0,0,0,0,24'h555555, 24'h000000,1,0,1,0,0};
        vecs[12] = '{0,0,0,0,1,24'h666666, 24'h000000,1,0,1,0,0};
        vecs[13] = '{0,0,0,0,0,24'h676767, 24'h000000,1,0,1,0,0};
        vecs[14] = '{0,0,0,0,1,24'h777777, 24'h777777,1,0,0,0,1};
        vecs[15] = '{0,1,1,0,0,24'h888888, 24'h888888,1,0,0,0,1};
        vecs[16] = '{0,0,0,0,0,24'h999999, 24'h999999,1,0,0,0,1};
        vecs[17] = '{0,1,0,1,1,24'hAAAAAA, 24'hAAAAAA,1,0,1,0,0};
        vecs[18] = '{0,1,0,1,1,24'hBBBBBB, 24'hBBBBBB,1,0,1,0,0};
        vecs[19] = '{0,0,0,0,0,24'hCCCCCC, 24'hCCCCCC,1,0,1,0,0};
        vecs[20] = '{0,0,0,0,1,24'hDDDDDD, 24'h000000,0,1,1,1,0};

        $display("[TB] directed vector table");
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].en, vecs[i].full, vecs[i].vs, vecs[i].din);
            tickClock();
            e = mkOuts(vecs[i].expDout, 1'b0, vecs[i].rst ? 1'b0 : vecs[i].vs, 1'b0,
                       vecs[i].expEn, vecs[i].expFull, vecs[i].expBusy,
                       vecs[i].expApplied, vecs[i].expReady);
            checkOutput($sformatf("vec%0d", i), 64'(sampleA()), 64'(e));
        end

        // reset while muting drops everything, including the change in flight
        $display("[TB] reset during mute");
        applyStimulus(1, 0, 0, 0, 1, 24'hFFFFFF);
        tickClock();
        checkOutput("muteReset", 64'(sampleA()), 64'(outs_t'('0)));
        applyStimulus(0, 0, 0, 0, 0, 24'h010203);
        tickClock();
        checkOutput("postReset", 64'(sampleA()), 64'(mkOuts(24'h010203,0,0,0,0,0,0,0,1)));
        applyStimulus(0, 0, 0, 0, 1, 24'h010203);
        tickClock();
        checkOutput("noStaleApply", 64'(sampleA()), 64'(mkOuts(24'h010203,0,1,0,0,0,0,0,1)));

        // vsync held static: the timeout stands in for missing frame edges
        $display("[TB] vsync timeout");
        applyStimulus(0, 1, 1, 1, 0, 24'h5A5A5A);
        tickClock();
        checkOutput("tmoAccept", 64'({busy, cfg_ready}), 64'(2'b10));
        cfg_valid = 1'b0;
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            tickClock();
            if (applied) begin
                n = k;
                break;
            end
        end
        checkOutput("tmoApplyCycle", 64'(n), 64'(TMO));
        checkOutput("tmoApplyCfg", 64'({ypbpr_en_o, ypbpr_full_o, dout}), 64'({2'b11, 24'h0}));
        m = 0;
        blackBad = 0;
        for (int k = 1; k <= 400; k++) begin
            tickClock();
            if (!busy) begin
                m = k;
                break;
            end
            if (dout != 24'h0) blackBad++;
        end
        checkOutput("tmoMuteLen", 64'(m), 64'(MF * TMO));
        checkOutput("tmoBlack", 64'(blackBad), 64'(0));
        checkOutput("tmoUnmute", 64'({dout, cfg_ready}), 64'({24'h5A5A5A, 1'b1}));

        // active-low vsync, no mute frames
        $display("[TB] active-low vsync without mute");
        checkOutput("bReady", 64'({cfg_ready_b, busy_b}), 64'(2'b10));
        cfg_valid_b = 1'b1; cfg_ypbpr_en = 1'b1; cfg_ypbpr_full = 1'b0;
        tickClock();
        checkOutput("bAccept", 64'({busy_b, cfg_ready_b, ypbpr_en_o_b}), 64'(3'b100));
        cfg_valid_b = 1'b0;
        vsync_b = 1'b1;
        tickClock();
        checkOutput("bRiseIgnored", 64'({busy_b, ypbpr_en_o_b, applied_b}), 64'(3'b100));
        vsync_b = 1'b0;
        din = 24'hC0FFEE;
        tickClock();
        checkOutput("bFallApply", 64'({ypbpr_en_o_b, ypbpr_full_o_b, applied_b, busy_b, cfg_ready_b, dout_b}),
                    64'({5'b10101, 24'hC0FFEE}));
        din = 24'h00BEEF;
        tickClock();
        checkOutput("bNoBlack", 64'({applied_b, dout_b}), 64'({1'b0, 24'h00BEEF}));

        // random traffic against the reference model
        $display("[TB] random traffic");
        applyStimulus(1, 0, 0, 0, 0, 24'h0);
        modelStep();
        tickClock();
        checkOutput("rndReset", 64'(sampleA()), 64'(mOut));
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(0, 399) == 0);
            cfg_valid      = ($urandom_range(0, 3) == 0);
            cfg_ypbpr_en   = 1'($urandom);
            cfg_ypbpr_full = 1'($urandom);
            din            = 24'($urandom);
            hsync          = 1'($urandom);
            csync          = 1'($urandom);
            if ($urandom_range(0, 59) == 0) vsync = ~vsync;
            modelStep();
            tickClock();
            checkOutput($sformatf("rnd%0d", c), 64'(sampleA()), 64'(mOut));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
